decode_operands: RTL and testbench

//   Operand-fetch/decode stage of the ARM-subset pipeline. Drives regfile read

---
 rtl/decode_operands.sv | 192 +++++++++++++++++++
 tb/tb_decode_operands.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/decode_operands.sv
// Operand-fetch/decode stage: drives regfile read indices from the fetched
// instruction, then registers the resolved operands, shifter carry and SPSR.
module decode_operands #(
    parameter int unsigned PC_READ_OFFSET = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] insn,
    input  logic [31:0] inpc,
    input  logic [31:0] incpsr,
    input  logic [31:0] inspsr,
    output logic [3:0]  read_0,
    output logic [3:0]  read_1,
    output logic [3:0]  read_2,
    input  logic [31:0] rdata_0,
    input  logic [31:0] rdata_1,
    input  logic [31:0] rdata_2,
    output logic [31:0] op0,
    output logic [31:0] op1,
    output logic [31:0] op2,
    output logic        carry,
    output logic [31:0] outspsr
);

    logic        c_in;
    logic        is_mul, is_swp, is_dp, is_ldst, is_ldm, is_br, sh_reg;
    logic [31:0] pc_rd;
    logic [31:0] val_0, val_1, val_2;

    logic [7:0]  amt;
    logic [1:0]  sh_type;
    logic [4:0]  rot;
    logic [63:0] ext;
    logic        rrx;
    logic [31:0] sh_res;
    logic        sh_c;

    logic [31:0] op0_d, op1_d, op2_d, spsr_d;
    logic        carry_d;
    logic [31:0] op0_q, op1_q, op2_q, spsr_q;
    logic        carry_q;

    // Instruction class decode, read indices and PC-substituted operand values
    always_comb begin
        c_in    = incpsr[29];
        is_mul  = (insn[27:22] == 6'b000000) && (insn[7:4] == 4'b1001);
        is_swp  = (insn[27:23] == 5'b00010) && (insn[21:20] == 2'b00) && (insn[7:4] == 4'b1001);
        is_dp   = (insn[27:26] == 2'b00) && !is_mul && !is_swp;
        is_ldst = (insn[27:26] == 2'b01);
        is_ldm  = (insn[27:25] == 3'b100);
        is_br   = (insn[27:25] == 3'b101);
        sh_reg  = is_dp && !insn[25] && insn[4];

        read_0 = is_mul  ? insn[15:12] : insn[19:16];
        read_1 = insn[3:0];
        read_2 = is_ldst ? insn[15:12] : insn[11:8];

        // PC reads one word further ahead when the shift amount comes from a register
        pc_rd = inpc + PC_READ_OFFSET + (sh_reg ? 32'd4 : 32'd0);
        val_0 = (read_0 == 4'hF) ? pc_rd : rdata_0;
        val_1 = (read_1 == 4'hF) ? pc_rd : rdata_1;
        val_2 = (read_2 == 4'hF) ? pc_rd : rdata_2;
    end

    // Barrel shifter: rotated immediate, shift-by-immediate or shift-by-register
    always_comb begin
        sh_type = insn[6:5];
        sh_res  = val_1;
        sh_c    = c_in;
        ext     = '0;
        amt     = '0;
        rot     = '0;
        rrx     = 1'b0;
        if (is_dp && insn[25]) begin
            rot    = {insn[11:8], 1'b0};
            sh_res = ({24'b0, insn[7:0]} >> rot) | ({24'b0, insn[7:0]} << (6'd32 - {1'b0, rot}));
            sh_c   = (insn[11:8] == 4'h0) ? c_in : sh_res[31];
        end else begin
            // Immediate LSR/ASR #0 encode a shift of 32; immediate ROR #0 is RRX
            if (sh_reg) begin
                amt = val_2[7:0];
            end else begin
                amt = {3'b000, insn[11:7]};
                if (insn[11:7] == 5'd0 && (sh_type == 2'b01 || sh_type == 2'b10))
                    amt = 8'd32;
                rrx = (insn[11:7] == 5'd0) && (sh_type == 2'b11);
            end
            if (rrx) begin
                sh_res = {c_in, val_1[31:1]};
                sh_c   = val_1[0];
            end else if (amt != 8'd0) begin
                case (sh_type)
                    2'b00: begin
                        if (amt > 8'd32) begin
                            sh_res = '0;
                            sh_c   = 1'b0;
                        end else begin
                            ext    = {32'b0, val_1} << amt;
                            sh_res = ext[31:0];
                            sh_c   = ext[32];
                        end
                    end
                    2'b01: begin
                        if (amt > 8'd32) begin
                            sh_res = '0;
                            sh_c   = 1'b0;
                        end else begin
                            ext    = {val_1, 32'b0} >> amt;
                            sh_res = ext[63:32];
                            sh_c   = ext[31];
                        end
                    end
                    2'b10: begin
                        if (amt >= 8'd32) begin
                            sh_res = {32{val_1[31]}};
                            sh_c   = val_1[31];
                        end else begin
                            ext    = $signed({val_1, 32'b0}) >>> amt;
                            sh_res = ext[63:32];
                            sh_c   = ext[31];
                        end
                    end
                    default: begin
                        rot = amt[4:0];
                        if (rot == 5'd0) begin
                            sh_res = val_1;
                            sh_c   = val_1[31];
                        end else begin
                            sh_res = (val_1 >> rot) | (val_1 << (6'd32 - {1'b0, rot}));
                            sh_c   = sh_res[31];
                        end
                    end
                endcase
            end
        end
    end

    // Operand selection per instruction class
    always_comb begin
        op0_d   = '0;
        op1_d   = '0;
        op2_d   = '0;
        carry_d = c_in;
        spsr_d  = inspsr;
        if (is_dp) begin
            op0_d   = val_0;
            op1_d   = sh_res;
            carry_d = sh_c;
        end else if (is_mul) begin
            op0_d = val_0;
            op1_d = val_1;
            op2_d = val_2;
        end else if (is_swp) begin
            op0_d = val_0;
            op1_d = val_1;
        end else if (is_ldst) begin
            op0_d = val_0;
            op1_d = insn[25] ? sh_res : {20'b0, insn[11:0]};
            op2_d = val_2;
        end else if (is_ldm) begin
            op0_d = val_0;
            op1_d = {16'b0, insn[15:0]};
        end else if (is_br) begin
            op0_d = inpc + PC_READ_OFFSET;
            op1_d = {{6{insn[23]}}, insn[23:0], 2'b00};
        end
    end

    // Output registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op0_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            carry_q <= 1'b0;
            spsr_q  <= '0;
        end else begin
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            carry_q <= carry_d;
            spsr_q  <= spsr_d;
        end
    end

    assign op0     = op0_q;
    assign op1     = op1_q;
    assign op2     = op2_q;
    assign carry   = carry_q;
    assign outspsr = spsr_q;

endmodule

// File: tb/tb_decode_operands.sv
// Directed scoreboard bench for decode_operands.
module tb_decode_operands;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] insn, inpc, incpsr, inspsr;
    logic [3:0]  read_0, read_1, read_2;
    logic [31:0] rdata_0, rdata_1, rdata_2;
    logic [31:0] op0, op1, op2, outspsr;
    logic        carry;

    logic [31:0] regs [16];

    int errors = 0;
    int checks = 0;
    int nstep  = 0;

    typedef struct {
        string       tag;
        logic [31:0] op0, op1, op2, spsr;
        logic        c;
        bit          chk_c;
    } exp_t;
    exp_t sb[$];

    decode_operands #(.PC_READ_OFFSET(8)) dut (
        .clk(clk), .rst(rst),
        .insn(insn), .inpc(inpc), .incpsr(incpsr), .inspsr(inspsr),
        .read_0(read_0), .read_1(read_1), .read_2(read_2),
        .rdata_0(rdata_0), .rdata_1(rdata_1), .rdata_2(rdata_2),
        .op0(op0), .op1(op1), .op2(op2), .carry(carry), .outspsr(outspsr)
    );

    always #5 clk = ~clk;

    assign rdata_0 = regs[read_0];
    assign rdata_1 = regs[read_1];
    assign rdata_2 = regs[read_2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reads(input string tag, input logic [3:0] r0, input logic [3:0] r1, input logic [3:0] r2);
        chk({tag, ".read_0"}, {28'b0, read_0}, {28'b0, r0});
        chk({tag, ".read_1"}, {28'b0, read_1}, {28'b0, r1});
        chk({tag, ".read_2"}, {28'b0, read_2}, {28'b0, r2});
    endtask

    // Drive one instruction, push its expectation, compare after the next edge
    task automatic step(input string tag, input logic [31:0] i, input logic [31:0] pc,
                        input logic cflag, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2, input logic ec, input bit chk_c);
        exp_t e, got;
        @(negedge clk);
        nstep++;
        insn   = i;
        inpc   = pc;
        incpsr = {2'b01, cflag, 29'h0};
        inspsr = 32'hA5000000 + nstep;
        e.tag = tag; e.op0 = e0; e.op1 = e1; e.op2 = e2; e.c = ec; e.chk_c = chk_c;
        e.spsr = 32'hA5000000 + nstep;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.scoreboard: observed=empty expected=entry", tag);
        end else begin
            got = sb.pop_front();
            chk({got.tag, ".op0"}, op0, got.op0);
            chk({got.tag, ".op1"}, op1, got.op1);
            chk({got.tag, ".op2"}, op2, got.op2);
            chk({got.tag, ".spsr"}, outspsr, got.spsr);
            if (got.chk_c) chk({got.tag, ".carry"}, {31'b0, carry}, {31'b0, got.c});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'h100 + i;
        regs[15] = 32'hBAD0BAD0;
        regs[1]  = 32'h5;
        regs[2]  = 32'h80000001;
        regs[3]  = 32'h1;
        regs[4]  = 32'd33;
        regs[5]  = 32'hDEADBEEF;
        regs[6]  = 32'h1000;
        regs[7]  = 32'h18000001;
        regs[9]  = 32'h80000001;
        regs[13] = 32'h3000;
        rst = 1'b1; insn = '0; inpc = '0; incpsr = '0; inspsr = 32'hFFFFFFFF;
        #12;
        chk("reset.op0", op0, '0);
        chk("reset.op1", op1, '0);
        chk("reset.op2", op2, '0);
        chk("reset.spsr", outspsr, '0);
        chk("reset.carry", {31'b0, carry}, '0);
        @(negedge clk);
        rst = 1'b0;

        step("add_imm", 32'hE28104FF, 32'h0, 1'b0, 32'h5, 32'hFF000000, 32'h0, 1'b1, 1'b1);
        chk_reads("add_imm", 4'h1, 4'hF, 4'h4);
        step("add_pc_imm", 32'hE28F0001, 32'h300, 1'b1, 32'h308, 32'h1, 32'h0, 1'b1, 1'b1);
        step("lsr0", 32'hE1A00022, 32'h0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1'b1);
        regs[2] = 32'h3;
        step("rrx", 32'hE1A00062, 32'h0, 1'b1, 32'h100, 32'h80000001, 32'h0, 1'b1, 1'b1);
        step("add_pc_lsl_r", 32'hE08F0413, 32'h100, 1'b1, 32'h10C, 32'h0, 32'h0, 1'b0, 1'b1);
        chk_reads("add_pc_lsl_r", 4'hF, 4'h3, 4'h4);
        step("branch", 32'hEAFFFFFE, 32'h200, 1'b1, 32'h208, 32'hFFFFFFF8, 32'h0, 1'b1, 1'b1);
        step("str_imm", 32'hE5865004, 32'h0, 1'b0, 32'h1000, 32'h4, 32'hDEADBEEF, 1'b0, 1'b0);
        chk_reads("str_imm", 4'h6, 4'h4, 4'h5);
        step("mla", 32'hE0203291, 32'h0, 1'b0, 32'h1, 32'h5, 32'h3, 1'b0, 1'b1);
        chk_reads("mla", 4'h3, 4'h1, 4'h2);
        step("lsl4", 32'hE1A00207, 32'h0, 1'b0, 32'h100, 32'h80000010, 32'h0, 1'b1, 1'b1);
        regs[2] = 32'h80000001;
        step("asr0", 32'hE1A00042, 32'h0, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);

        // Mid-stream reset: outputs clear without a clock edge
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst.op0", op0, '0);
        chk("midrst.op1", op1, '0);
        chk("midrst.spsr", outspsr, '0);
        chk("midrst.carry", {31'b0, carry}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        regs[8] = 32'd32;
        step("ror_r32", 32'hE1A00877, 32'h0, 1'b1, 32'h100, 32'h18000001, 32'h0, 1'b0, 1'b1);
        regs[8] = 32'd40;
        step("asr_r40", 32'hE1A00859, 32'h0, 1'b0, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        regs[8] = 32'd4;
        step("lsr_r4", 32'hE1A00839, 32'h0, 1'b1, 32'h100, 32'h08000000, 32'h0, 1'b0, 1'b1);
        regs[8] = 32'd0;
        step("lsl_r0", 32'hE1A00819, 32'h0, 1'b1, 32'h100, 32'h80000001, 32'h0, 1'b1, 1'b1);
        step("ldm", 32'hE8BD00F0, 32'h0, 1'b1, 32'h3000, 32'h000000F0, 32'h0, 1'b1, 1'b1);
        step("coproc", 32'hEE000000, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
